// File: rtl/instr_encoder_loader.sv
// Symbolic-instruction to RV32I encoder and sequential instruction-memory loader.
// Accepts mnemonic/register/immediate fields over valid/ready and writes one
// encoded word per transfer, starting from a captured base address. The
// session ends at ECALL (done) or on an illegal instruction or overflow (error).
module instr_encoder_loader #(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 256,
  localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  typedef enum logic [3:0] {
    M_ADD  = 4'd0, M_SUB = 4'd1, M_ADDI = 4'd2, M_LW  = 4'd3, M_SW    = 4'd4,
    M_BEQ  = 4'd5, M_BNE = 4'd6, M_JAL  = 4'd7, M_JALR = 4'd8, M_ECALL = 4'd9
  } mnem_t;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic              ecall_pending;

  logic signed [31:0] simm;
  logic               i_ok, b_ok, j_ok;
  logic [31:0]        enc_word;
  logic               bad_instr;
  logic               is_ecall;
  logic               full;
  logic               transfer;

  assign simm     = in_imm;
  assign i_ok     = (simm >= -32'sd2048)    && (simm <= 32'sd2047);
  assign b_ok     = (simm >= -32'sd4096)    && (simm <= 32'sd4094) && !in_imm[0];
  assign j_ok     = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !in_imm[0];
  assign full     = (word_count == CNT_W'(MAX_WORDS));
  assign transfer = in_valid && in_ready;

  // Pack the presented fields into an RV32I word and flag unencodable input.
  always_comb begin
    enc_word  = '0;
    bad_instr = 1'b0;
    is_ecall  = 1'b0;
    case (in_mnem)
      M_ADD:   enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      M_SUB:   enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      M_ADDI: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
        bad_instr = !i_ok;
      end
      M_LW: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        bad_instr = !i_ok;
      end
      M_JALR: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
        bad_instr = !i_ok;
      end
      M_SW: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        bad_instr = !i_ok;
      end
      M_BEQ, M_BNE: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                     (in_mnem == M_BNE) ? 3'b001 : 3'b000,
                     in_imm[4:1], in_imm[11], 7'b1100011};
        bad_instr = !b_ok;
      end
      M_JAL: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        bad_instr = !j_ok;
      end
      M_ECALL: begin
        enc_word = 32'h0000_0073;
        is_ecall = 1'b1;
      end
      default: bad_instr = 1'b1;
    endcase
  end

  // Session FSM with registered handshake, write strobe and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      next_addr     <= '0;
      ecall_pending <= 1'b0;
      in_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      word_count    <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= RUN;
            next_addr     <= base_addr & ~ADDR_W'(3);
            word_count    <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            ecall_pending <= 1'b0;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
          end
        end
        RUN: begin
          // ECALL stays in RUN for its write cycle with in_ready already low,
          // then completes the session on the following edge.
          if (ecall_pending) begin
            state         <= DONE;
            done          <= 1'b1;
            busy          <= 1'b0;
            ecall_pending <= 1'b0;
          end else if (transfer) begin
            if (bad_instr || full) begin
              state    <= ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= next_addr;
              imem_wdata <= enc_word;
              next_addr  <= next_addr + ADDR_W'(4);
              word_count <= word_count + CNT_W'(1);
              if (is_ecall) begin
                ecall_pending <= 1'b1;
                in_ready      <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes are queued at each
// accepted transfer and compared when the memory write strobe appears.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_mnem = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;

  logic        in_ready, imem_we, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  word_count;

  logic        in_ready2, imem_we2, busy2, done2, error2;
  logic [31:0] imem_addr2, imem_wdata2;
  logic [2:0]  word_count2;

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  instr_encoder_loader #(.ADDR_W(32), .MAX_WORDS(4)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_mnem(in_mnem),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .done(done2), .error(error2), .word_count(word_count2)
  );

  int checks = 0;
  int passes = 0;
  logic [63:0] q  [$];
  logic [63:0] q2 [$];
  logic [31:0] exp_addr, exp_addr2;
  int exp_count = 0;
  int cyc = 0, last_wr = 0, last_gap = 0, writes2 = 0;

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (imem_we) begin
      checks++;
      if (q.size() == 0) $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
      else begin
        e = q.pop_front();
        if ({imem_addr, imem_wdata} !== e)
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h", imem_addr, imem_wdata, e[63:32], e[31:0]);
        else passes++;
      end
      last_gap = cyc - last_wr;
      last_wr  = cyc;
    end
    if (imem_we2) begin
      writes2++;
      checks++;
      if (q2.size() == 0) $display("FAIL unexpected_write_small addr=%h data=%h", imem_addr2, imem_wdata2);
      else begin
        e = q2.pop_front();
        if ({imem_addr2, imem_wdata2} !== e)
          $display("FAIL write_small got addr=%h data=%h want addr=%h data=%h", imem_addr2, imem_wdata2, e[63:32], e[31:0]);
        else passes++;
      end
    end
  end

  task automatic start_sess(input bit sel, input logic [31:0] base);
    base_addr = base;
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
    if (sel) exp_addr2 = base & ~32'd3;
    else begin exp_addr = base & ~32'd3; exp_count = 0; end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until accepted; queue its expected write.
  task automatic send(input bit sel, input logic [3:0] m, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input bit expect_wr, input logic [31:0] exp_data);
    bit rdy = 1'b0;
    in_valid = 1'b1; in_mnem = m; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = sel ? in_ready2 : in_ready;
      if (rdy) break;
    end
    if (!rdy) begin
      checks++;
      $display("FAIL send_timeout mnem=%0d in_ready stayed 0, want 1", m);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (expect_wr) begin
      if (sel) begin q2.push_back({exp_addr2, exp_data}); exp_addr2 += 32'd4; end
      else begin q.push_back({exp_addr, exp_data}); exp_addr += 32'd4; exp_count++; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({in_ready, imem_we, busy, done, error} !== 5'b0 || word_count !== 9'd0 ||
        imem_addr !== 32'd0 || imem_wdata !== 32'd0)
      $display("FAIL reset got rdy=%b we=%b busy=%b done=%b err=%b cnt=%0d addr=%h data=%h want all 0",
               in_ready, imem_we, busy, done, error, word_count, imem_addr, imem_wdata);
    else passes++;
  endtask

  task automatic test_basic;
    start_sess(0, 32'h100);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) $display("FAIL start_ready got rdy=%b busy=%b want 1 1", in_ready, busy);
    else passes++;
    send(0, 4'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h0050_0093);
    @(negedge clk);
    checks++;
    if (word_count !== 9'd1) $display("FAIL basic_count got %0d want 1", word_count);
    else passes++;
    idle(1);
  endtask

  task automatic test_back_to_back;
    send(0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h0020_81B3);
    send(0, 4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h4020_81B3);
    idle(1);
    checks++;
    if (last_gap !== 1) $display("FAIL b2b_gap got %0d cycles want 1", last_gap);
    else passes++;
  endtask

  task automatic test_encodings;
    send(0, 4'd4, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h0020_A423);
    send(0, 4'd5, 5'd0, 5'd1, 5'd2, -32'sd4, 1, 32'hFE20_8EE3);
    send(0, 4'd7, 5'd1, 5'd0, 5'd0, 32'd8, 1, 32'h0080_00EF);
    send(0, 4'd3, 5'd5, 5'd6, 5'd0, -32'sd4, 1, 32'hFFC3_2283);
    send(0, 4'd6, 5'd0, 5'd3, 5'd4, 32'd16, 1, 32'h0041_9863);
    send(0, 4'd8, 5'd0, 5'd1, 5'd0, 32'd0, 1, 32'h0000_8067);
    idle(1);
  endtask

  task automatic test_ecall;
    send(0, 4'd9, 5'd0, 5'd0, 5'd0, 32'd0, 1, 32'h0000_0073);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0) $display("FAIL ecall_write_cycle got rdy=%b done=%b want 0 0", in_ready, done);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL ecall_done got done=%b busy=%b rdy=%b want 1 0 0", done, busy, in_ready);
    else passes++;
    in_valid = 1'b1; in_mnem = 4'd2; in_imm = 32'd1;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || word_count !== 9'(exp_count) || exp_count != 10)
      $display("FAIL ecall_hold got done=%b cnt=%0d want 1 10", done, word_count);
    else passes++;
    idle(1);
  endtask

  task automatic expect_error(input string tag, input int cnt);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || word_count !== 9'(cnt))
      $display("FAIL %s got err=%b rdy=%b cnt=%0d want 1 0 %0d", tag, error, in_ready, word_count, cnt);
    else passes++;
    idle(3);
  endtask

  task automatic test_faults;
    start_sess(0, 32'h203);
    send(0, 4'd2, 5'd1, 5'd0, 5'd0, 32'd7, 1, 32'h0070_0093);
    send(0, 4'd2, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 32'd0);
    expect_error("fault_addi_2048", 1);
    start_sess(0, 32'h300);
    checks++;
    if (error !== 1'b0 || word_count !== 9'd0 || in_ready !== 1'b1)
      $display("FAIL restart_clear got err=%b cnt=%0d rdy=%b want 0 0 1", error, word_count, in_ready);
    else passes++;
    send(0, 4'd5, 5'd0, 5'd1, 5'd2, 32'd3, 0, 32'd0);
    expect_error("fault_beq_odd", 0);
    start_sess(0, 32'h400);
    send(0, 4'd2, 5'd1, 5'd0, 5'd0, -32'sd2048, 1, 32'h8000_0093);
    send(0, 4'd2, 5'd1, 5'd0, 5'd0, 32'd2047, 1, 32'h7FF0_0093);
    send(0, 4'd5, 5'd0, 5'd0, 5'd0, 32'd4094, 1, 32'h7E00_0FE3);
    send(0, 4'd7, 5'd0, 5'd0, 5'd0, -32'sd1048576, 1, 32'h8000_006F);
    send(0, 4'd7, 5'd0, 5'd0, 5'd0, 32'd1048576, 0, 32'd0);
    expect_error("fault_jal_range", 4);
    start_sess(0, 32'h600);
    send(0, 4'd10, 5'd1, 5'd0, 5'd0, 32'd0, 0, 32'd0);
    expect_error("fault_bad_mnem", 0);
  endtask

  task automatic test_rst_midstream;
    start_sess(0, 32'h500);
    send(0, 4'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h0050_0093);
    in_mnem = 4'd0; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, imem_we, busy, done, error} !== 5'b0 || word_count !== 9'd0 ||
        imem_addr !== 32'd0 || imem_wdata !== 32'd0)
      $display("FAIL rst_mid got rdy=%b we=%b busy=%b done=%b err=%b cnt=%0d addr=%h data=%h want all 0",
               in_ready, imem_we, busy, done, error, word_count, imem_addr, imem_wdata);
    else passes++;
    idle(2);
  endtask

  task automatic test_wrap;
    start_sess(0, 32'hFFFF_FFFC);
    send(0, 4'd2, 5'd1, 5'd0, 5'd0, 32'd1, 1, 32'h0010_0093);
    send(0, 4'd2, 5'd2, 5'd0, 5'd0, 32'd2, 1, 32'h0020_0113);
    send(0, 4'd9, 5'd0, 5'd0, 5'd0, 32'd0, 1, 32'h0000_0073);
    idle(3);
    checks++;
    if (done !== 1'b1 || word_count !== 9'd3) $display("FAIL wrap_done got done=%b cnt=%0d want 1 3", done, word_count);
    else passes++;
  endtask

  task automatic test_max_words;
    start_sess(1, 32'h0);
    for (int k = 1; k <= 5; k++)
      send(1, 4'd2, 5'd1, 5'd0, 5'd0, 32'(k), k <= 4, (32'(k) << 20) | 32'h0000_0093);
    @(negedge clk);
    checks++;
    if (error2 !== 1'b1 || word_count2 !== 3'd4 || in_ready2 !== 1'b0)
      $display("FAIL max_words got err=%b cnt=%0d rdy=%b want 1 4 0", error2, word_count2, in_ready2);
    else passes++;
    idle(3);
    checks++;
    if (writes2 != 4) $display("FAIL max_words_writes got %0d want 4", writes2);
    else passes++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic;
    test_back_to_back;
    test_encodings;
    test_ecall;
    test_faults;
    test_rst_midstream;
    test_wrap;
    test_max_words;
    idle(2);
    checks++;
    if (q.size() != 0 || q2.size() != 0)
      $display("FAIL missing_writes got pending=%0d/%0d want 0/0", q.size(), q2.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
